// File: rtl/gato_arbitro_if.sv
// Board-register and referee-status bundle shared by the cell selector,
// the display logic and the gato_arbitro referee.
interface gato_arbitro_if;
  logic [1:0] guarda_c1, guarda_c2, guarda_c3;
  logic [1:0] guarda_c4, guarda_c5, guarda_c6;
  logic [1:0] guarda_c7, guarda_c8, guarda_c9;
  logic       boton_reinicio;
  logic       turno_p1, turno_p2;
  logic       gana_p1, gana_p2, empate;
  logic       fin_juego, jugada_invalida;
  logic [2:0] linea_ganadora;
  logic [3:0] jugadas;
  logic       tiempo_agotado;

  modport master (
    output guarda_c1, guarda_c2, guarda_c3, guarda_c4, guarda_c5,
           guarda_c6, guarda_c7, guarda_c8, guarda_c9, boton_reinicio,
    input  turno_p1, turno_p2, gana_p1, gana_p2, empate, fin_juego,
           jugada_invalida, linea_ganadora, jugadas, tiempo_agotado
  );

  modport slave (
    input  guarda_c1, guarda_c2, guarda_c3, guarda_c4, guarda_c5,
           guarda_c6, guarda_c7, guarda_c8, guarda_c9, boton_reinicio,
    output turno_p1, turno_p2, gana_p1, gana_p2, empate, fin_juego,
           jugada_invalida, linea_ganadora, jugadas, tiempo_agotado
  );
endinterface

// File: rtl/gato_arbitro.sv
// Tic-tac-toe referee: validates each new mark against a shadow board and
// scans the eight lines serially. GATO_TIMEOUT_EN adds a per-turn forfeit timer.
module gato_arbitro #(
  parameter logic [23:0] TIMEOUT_CICLOS = 24'd12_000_000
) (
  input  logic          clk,
  input  logic          reset,
  gato_arbitro_if.slave bus
);

  typedef enum logic [2:0] {ESPERA_P1, ESPERA_P2, EVALUA, FIN, ERROR} estado_t;

  estado_t    estado, estado_d;
  logic [1:0] sombra   [9];
  logic [1:0] sombra_d [9];
  logic [1:0] tablero  [9];
  logic [3:0] jugadas_q, jugadas_d;
  logic [3:0] indice, indice_d;
  logic [2:0] linea_q, linea_d;
  logic       gana1_q, gana1_d, gana2_q, gana2_d, empate_q, empate_d;
  logic       hallado, hallado_d, mover_p1, mover_p1_d;
  logic       tiempo_q, tiempo_d;

  logic [1:0] codigo_turno, codigo_mover;
  logic [3:0] n_cambios;
  logic       celda_mala;
  logic [3:0] ca, cb, cc;
  logic       linea_gana;
  logic       plazo_vencido;

  assign tablero = '{bus.guarda_c1, bus.guarda_c2, bus.guarda_c3,
                     bus.guarda_c4, bus.guarda_c5, bus.guarda_c6,
                     bus.guarda_c7, bus.guarda_c8, bus.guarda_c9};

  assign codigo_turno = (estado == ESPERA_P2) ? 2'b01 : 2'b11;
  assign codigo_mover = mover_p1 ? 2'b11 : 2'b01;

  // A legal move is exactly one change, into an empty cell, with the mover's code.
  always_comb begin
    n_cambios  = '0;
    celda_mala = 1'b0;
    for (int unsigned i = 0; i < 9; i++) begin
      if (tablero[i] != sombra[i]) begin
        n_cambios = n_cambios + 4'd1;
        if (sombra[i] != 2'b00 || tablero[i] != codigo_turno)
          celda_mala = 1'b1;
      end
    end
  end

  always_comb begin
    ca = 4'd0; cb = 4'd1; cc = 4'd2;
    unique case (indice[2:0])
      3'd0: begin ca = 4'd0; cb = 4'd1; cc = 4'd2; end
      3'd1: begin ca = 4'd3; cb = 4'd4; cc = 4'd5; end
      3'd2: begin ca = 4'd6; cb = 4'd7; cc = 4'd8; end
      3'd3: begin ca = 4'd0; cb = 4'd3; cc = 4'd6; end
      3'd4: begin ca = 4'd1; cb = 4'd4; cc = 4'd7; end
      3'd5: begin ca = 4'd2; cb = 4'd5; cc = 4'd8; end
      3'd6: begin ca = 4'd0; cb = 4'd4; cc = 4'd8; end
      3'd7: begin ca = 4'd2; cb = 4'd4; cc = 4'd6; end
    endcase
  end

  assign linea_gana = (sombra[ca] == codigo_mover) && (sombra[cb] == codigo_mover)
                   && (sombra[cc] == codigo_mover);

`ifdef GATO_TIMEOUT_EN
  logic [23:0] cuenta;

  assign plazo_vencido = (cuenta == TIMEOUT_CICLOS - 24'd1);

  always_ff @(posedge clk) begin
    if (reset)
      cuenta <= '0;
    else if (estado_d != estado || (estado != ESPERA_P1 && estado != ESPERA_P2))
      cuenta <= '0;
    else
      cuenta <= cuenta + 24'd1;
  end
`else
  logic timeout_unused;
  assign timeout_unused = |TIMEOUT_CICLOS;
  assign plazo_vencido  = 1'b0;
`endif

  always_comb begin
    estado_d   = estado;
    sombra_d   = sombra;
    jugadas_d  = jugadas_q;
    indice_d   = indice;
    linea_d    = linea_q;
    gana1_d    = gana1_q;
    gana2_d    = gana2_q;
    empate_d   = empate_q;
    hallado_d  = hallado;
    mover_p1_d = mover_p1;
    tiempo_d   = 1'b0;
    unique case (estado)
      ESPERA_P1, ESPERA_P2: begin
        if (n_cambios == 4'd1 && !celda_mala) begin
          sombra_d   = tablero;
          jugadas_d  = jugadas_q + 4'd1;
          mover_p1_d = (estado == ESPERA_P1);
          indice_d   = '0;
          hallado_d  = 1'b0;
          estado_d   = EVALUA;
        end else if (n_cambios != 4'd0) begin
          estado_d = ERROR;
        end else if (plazo_vencido) begin
          tiempo_d = 1'b1;
          estado_d = (estado == ESPERA_P1) ? ESPERA_P2 : ESPERA_P1;
        end
      end
      // indice 0..7 scans lines; indice 8 is the extra cycle that publishes the result.
      EVALUA: begin
        if (indice == 4'd8) begin
          if (hallado) begin
            gana1_d  = mover_p1;
            gana2_d  = !mover_p1;
            estado_d = FIN;
          end else if (jugadas_q == 4'd9) begin
            empate_d = 1'b1;
            estado_d = FIN;
          end else begin
            estado_d = mover_p1 ? ESPERA_P2 : ESPERA_P1;
          end
        end else begin
          indice_d = indice + 4'd1;
          if (linea_gana && !hallado) begin
            hallado_d = 1'b1;
            linea_d   = indice[2:0];
          end
        end
      end
      FIN, ERROR: begin
        if (bus.boton_reinicio) begin
          estado_d   = ESPERA_P1;
          sombra_d   = tablero;
          jugadas_d  = '0;
          indice_d   = '0;
          linea_d    = '0;
          gana1_d    = 1'b0;
          gana2_d    = 1'b0;
          empate_d   = 1'b0;
          hallado_d  = 1'b0;
          mover_p1_d = 1'b0;
        end
      end
      default: estado_d = ESPERA_P1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado    <= ESPERA_P1;
      sombra    <= '{default: 2'b00};
      jugadas_q <= '0;
      indice    <= '0;
      linea_q   <= '0;
      gana1_q   <= 1'b0;
      gana2_q   <= 1'b0;
      empate_q  <= 1'b0;
      hallado   <= 1'b0;
      mover_p1  <= 1'b0;
      tiempo_q  <= 1'b0;
    end else begin
      estado    <= estado_d;
      sombra    <= sombra_d;
      jugadas_q <= jugadas_d;
      indice    <= indice_d;
      linea_q   <= linea_d;
      gana1_q   <= gana1_d;
      gana2_q   <= gana2_d;
      empate_q  <= empate_d;
      hallado   <= hallado_d;
      mover_p1  <= mover_p1_d;
      tiempo_q  <= tiempo_d;
    end
  end

  assign bus.turno_p1        = (estado == ESPERA_P1);
  assign bus.turno_p2        = (estado == ESPERA_P2);
  assign bus.fin_juego       = (estado == FIN);
  assign bus.jugada_invalida = (estado == ERROR);
  assign bus.gana_p1         = gana1_q;
  assign bus.gana_p2         = gana2_q;
  assign bus.empate          = empate_q;
  assign bus.linea_ganadora  = linea_q;
  assign bus.jugadas         = jugadas_q;
  assign bus.tiempo_agotado  = tiempo_q;

endmodule

// File: doc/gato_arbitro.md
# gato_arbitro

Game referee for the tic-tac-toe board: the reading side of the cell-selector's board registers. Each cycle it samples the nine 2-bit cell codes, detects a newly placed mark, and checks it is legal for the current player. It then scans the eight winning lines sequentially and drives the turn, win, draw and error outputs back to the selector and display logic.

## Interface
- `TIMEOUT_CICLOS`, default 24'd12_000_000: idle cycles per turn before the turn is forfeited (used only with `GATO_TIMEOUT_EN`).
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `boton_reinicio`  in  1  new-game request, level-sampled, honoured only in FIN or ERROR.
- `guarda_c1`..`guarda_c9`  in  2 each  cell codes: 00 empty, 11 player 1 (X), 01 player 2 (O), 10 illegal.
  - Cells are numbered 1..9, row-major; cells 1-3 form the bottom row.
- `turno_p1`, `turno_p2`  out  1 each  one-hot turn; both 0 outside the ESPERA states.
- `gana_p1`, `gana_p2`, `empate`  out  1 each  sticky result flags.
- `fin_juego`  out  1  high in FIN.
- `jugada_invalida`  out  1  high in ERROR.
- `linea_ganadora`  out  3  index 0..7 of the completed line; valid when `gana_*` is high.
- `jugadas`  out  4  count of accepted moves, 0..9.
- `tiempo_agotado`  out  1  one-cycle pulse on turn forfeit.

## Operation
- Registered shadow board `sombra[1..9]` holds the last accepted board.
- Reset values:
  - `turno_p1`=1; every other output 0.
  - `sombra`=all 00; line index 0; timeout counter 0.
  - State ESPERA_P1.
- States: ESPERA_P1, ESPERA_P2, EVALUA, FIN, ERROR.
- ESPERA_Px: compare board to `sombra` every cycle.
  - No difference: stay.
  - Exactly one cell differs, its shadow value is 00 and its new code is the current player's (11 for P1, 01 for P2):
    - Load board into `sombra`; `jugadas`+1.
    - Latch mover identity; go to EVALUA.
  - Any other difference (two or more cells changed, an occupied cell changed, wrong code, code 10): go to ERROR.
- EVALUA: one line per cycle, index 0..7 in this order: rows {1,2,3},{4,5,6},{7,8,9}; columns {1,4,7},{2,5,8},{3,6,9}; diagonals {1,5,9},{3,5,7}.
  - A line wins when all three shadow cells equal the mover's code.
  - All 8 lines are always scanned, with no early exit.
  - The first winning index is latched into `linea_ganadora`.
- End of scan:
  - Win: set `gana_p1`/`gana_p2`, go to FIN.
  - Else `jugadas`==9: set `empate`, go to FIN.
  - Else go to the other player's ESPERA state.
  - Win on the ninth move reports a win, not a draw.
- FIN and ERROR: board ignored, outputs held.
  - `boton_reinicio`=1 restores the full reset state on the next edge, except `sombra`, which loads the current board.
- Simultaneous events:
  - `reset` overrides everything.
  - A board change during EVALUA is ignored until ESPERA is re-entered; it is then compared against the updated `sombra`.
- `reset` during EVALUA discards the move in progress; no result flag is set.

## Timing
- A move sampled at edge k enters EVALUA at edge k.
- Lines 0..7 are checked on edges k+1..k+8.
- The result (turn flip, `gana_*`, `empate`, `fin_juego`) is visible after edge k+9.
- `jugadas` increments at edge k.
- ERROR is entered at the edge the illegal board is first sampled; `jugada_invalida` is high from that edge on.
- The turn outputs are 0 on edges k+1..k+9.

## Configuration
- `GATO_TIMEOUT_EN` defined:
  - 24-bit counter runs in ESPERA states and clears on every state change.
  - On reaching `TIMEOUT_CICLOS`-1 the turn passes to the other player and `tiempo_agotado` pulses for one cycle.
  - `jugadas` is unchanged by a forfeit.
- `GATO_TIMEOUT_EN` undefined: no counter is built, `tiempo_agotado` is tied 0 and `TIMEOUT_CICLOS` is ignored.

## Test plan
- Reset, board all 00 for 20 cycles -> `turno_p1`=1, `jugadas`=0, no flags.
- P1 sets c5=11 at edge k -> `turno_*`=0 during k+1..k+9, then `turno_p2`=1, `jugadas`=1.
- Alternate X:1,O:4,X:2,O:5,X:3 -> `gana_p1`=1, `linea_ganadora`=0, `fin_juego`=1, `jugadas`=5; `boton_reinicio` -> `turno_p1`=1, `jugadas`=0.
- Nine legal moves, no line (X:1,O:2,X:3,O:5,X:4,O:6,X:8,O:7,X:9) -> `empate`=1, `gana_*`=0; variant where the ninth move completes diagonal {3,5,7} -> `gana_p1`=1, `linea_ganadora`=7, `empate`=0.
- Illegal cases: P1 writes 01; two cells change in one cycle; an occupied cell is overwritten -> `jugada_invalida`=1 held, `jugadas` unchanged.
- With `GATO_TIMEOUT_EN` and `TIMEOUT_CICLOS`=10, no move -> `tiempo_agotado` pulses after 10 cycles in ESPERA_P1, then `turno_p2`=1; `reset` asserted on edge k+4 of EVALUA -> `turno_p1`=1, `jugadas`=0, no result flags.
